// File: rtl/id_ex_elastic.sv
// ID->EX elastic pipeline register: 1-cycle latency, bubbles carry an all-zero payload, flush/reset clear all entries.
// Backpressure: define ID_EX_ELASTIC_SKID_EN for a skid entry with registered input_ready; otherwise input_ready = !output_valid || output_ready.
module id_ex_elastic #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int INST_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              input_valid,
  output logic              input_ready,
  input  logic [ADDR_W-1:0] input_addr,
  input  logic [INST_W-1:0] input_inst,
  input  logic [REG_W-1:0]  input_write_reg,
  input  logic [DATA_W-1:0] input_rsvalue,
  input  logic [DATA_W-1:0] input_rtvalue,
  input  logic [DATA_W-1:0] input_imm,
  output logic              output_valid,
  input  logic              output_ready,
  output logic [ADDR_W-1:0] output_addr,
  output logic [INST_W-1:0] output_inst,
  output logic [REG_W-1:0]  output_write_reg,
  output logic [DATA_W-1:0] output_rsvalue,
  output logic [DATA_W-1:0] output_rtvalue,
  output logic [DATA_W-1:0] output_imm,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
    logic [REG_W-1:0]  write_reg;
    logic [DATA_W-1:0] rsvalue;
    logic [DATA_W-1:0] rtvalue;
    logic [DATA_W-1:0] imm;
  } entry_t;

  entry_t in_dat;
  entry_t main_dat;
  logic   main_vld;
  logic   accept;
  logic   consume;

  assign in_dat.addr      = input_addr;
  assign in_dat.inst      = input_inst;
  assign in_dat.write_reg = input_write_reg;
  assign in_dat.rsvalue   = input_rsvalue;
  assign in_dat.rtvalue   = input_rtvalue;
  assign in_dat.imm       = input_imm;

  assign accept  = input_valid && input_ready;
  assign consume = main_vld && output_ready;

`ifdef ID_EX_ELASTIC_SKID_EN
  entry_t skid_dat;
  logic   skid_vld;

  // Ready depends only on state, so output_ready never reaches input_ready.
  assign input_ready = !skid_vld;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      main_vld <= 1'b0;
      main_dat <= '0;
      skid_vld <= 1'b0;
      skid_dat <= '0;
    end else if (skid_vld) begin
      // Skid full implies main full and input blocked; drain skid into main.
      if (consume) begin
        main_dat <= skid_dat;
        skid_vld <= 1'b0;
        skid_dat <= '0;
      end
    end else if (!main_vld || consume) begin
      main_vld <= accept;
      main_dat <= accept ? in_dat : '0;
    end else if (accept) begin
      skid_vld <= 1'b1;
      skid_dat <= in_dat;
    end
  end

  assign occupancy = {1'b0, main_vld} + {1'b0, skid_vld};
`else
  assign input_ready = !main_vld || output_ready;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      main_vld <= 1'b0;
      main_dat <= '0;
    end else if (!main_vld || consume) begin
      main_vld <= accept;
      main_dat <= accept ? in_dat : '0;
    end
  end

  assign occupancy = {1'b0, main_vld};
`endif

  // main_dat is zeroed whenever main_vld drops, so bubbles present a NOP payload.
  assign output_valid     = main_vld;
  assign output_addr      = main_dat.addr;
  assign output_inst      = main_dat.inst;
  assign output_write_reg = main_dat.write_reg;
  assign output_rsvalue   = main_dat.rsvalue;
  assign output_rtvalue   = main_dat.rtvalue;
  assign output_imm       = main_dat.imm;

endmodule

// File: tb/tb_id_ex_elastic.sv
// Scoreboard bench for id_ex_elastic: driver pushes accepted entries, negedge monitor checks
// outputs against a capacity-bounded queue model of the stage.
module tb_id_ex_elastic;
  localparam int AW = 40;
  localparam int DW = 64;
  localparam int RW = 5;
  localparam int IW = 32;
  localparam int CW = 300;
`ifdef ID_EX_ELASTIC_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] inst;
    logic [RW-1:0] write_reg;
    logic [DW-1:0] rsvalue;
    logic [DW-1:0] rtvalue;
    logic [DW-1:0] imm;
  } ent_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          input_valid = 1'b0;
  logic          input_ready;
  logic [AW-1:0] input_addr = '0;
  logic [IW-1:0] input_inst = '0;
  logic [RW-1:0] input_write_reg = '0;
  logic [DW-1:0] input_rsvalue = '0;
  logic [DW-1:0] input_rtvalue = '0;
  logic [DW-1:0] input_imm = '0;
  logic          output_valid;
  logic          output_ready = 1'b0;
  logic [AW-1:0] output_addr;
  logic [IW-1:0] output_inst;
  logic [RW-1:0] output_write_reg;
  logic [DW-1:0] output_rsvalue;
  logic [DW-1:0] output_rtvalue;
  logic [DW-1:0] output_imm;
  logic [1:0]    occupancy;

  always #5 clock = ~clock;

  id_ex_elastic #(.ADDR_W(AW), .DATA_W(DW), .REG_W(RW), .INST_W(IW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .input_valid(input_valid), .input_ready(input_ready),
    .input_addr(input_addr), .input_inst(input_inst), .input_write_reg(input_write_reg),
    .input_rsvalue(input_rsvalue), .input_rtvalue(input_rtvalue), .input_imm(input_imm),
    .output_valid(output_valid), .output_ready(output_ready),
    .output_addr(output_addr), .output_inst(output_inst), .output_write_reg(output_write_reg),
    .output_rsvalue(output_rsvalue), .output_rtvalue(output_rtvalue), .output_imm(output_imm),
    .occupancy(occupancy)
  );

  ent_t sb_q[$];
  int   held = 0;
  bit   acc_now = 1'b0;
  bit   mon_en = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc = 0;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stage is a FIFO of CAP entries; without the skid it can also accept while its sole entry leaves.
  function automatic bit model_ready(input bit ordy);
    if (CAP == 2) return held < 2;
    return (held == 0) || ordy;
  endfunction

  always @(negedge clock) begin
    if (mon_en) begin
      ent_t act;
      act.addr      = output_addr;
      act.inst      = output_inst;
      act.write_reg = output_write_reg;
      act.rsvalue   = output_rsvalue;
      act.rtvalue   = output_rtvalue;
      act.imm       = output_imm;
      chk("output_valid", CW'(output_valid), CW'(held > 0));
      chk("occupancy", CW'(occupancy), CW'(held));
      chk("input_ready", CW'(input_ready), CW'(model_ready(output_ready)));
      if (held > 0) chk("payload", CW'(act), CW'(sb_q[0]));
      else          chk("bubble_zero", CW'(act), '0);
      if (reset || flush) begin
        sb_q.delete();
        held = 0;
      end else begin
        if (held > 0 && output_ready) begin
          void'(sb_q.pop_front());
          held--;
        end
        if (acc_now) held++;
      end
    end
  end

  task automatic step(input bit v, input bit rdy, input bit fl, input bit rs, input ent_t e);
    @(posedge clock);
    #1;
    reset           = rs;
    flush           = fl;
    input_valid     = v;
    output_ready    = rdy;
    input_addr      = e.addr;
    input_inst      = e.inst;
    input_write_reg = e.write_reg;
    input_rsvalue   = e.rsvalue;
    input_rtvalue   = e.rtvalue;
    input_imm       = e.imm;
    acc_now = v && model_ready(rdy) && !fl && !rs;
    if (acc_now) begin
      sb_q.push_back(e);
      n_acc++;
    end
  endtask

  function automatic ent_t rand_ent();
    ent_t r;
    r.addr      = AW'({$urandom(), $urandom()});
    r.inst      = $urandom();
    r.write_reg = RW'($urandom());
    r.rsvalue   = {$urandom(), $urandom()};
    r.rtvalue   = {$urandom(), $urandom()};
    r.imm       = {$urandom(), $urandom()};
    return r;
  endfunction

  initial begin
    ent_t e;
    int start;
    int cyc;

    // Reset held two cycles while upstream offers an entry.
    e = '0;
    e.inst = 32'h2402000A;
    step(1, 0, 0, 1, e);
    mon_en = 1'b1;
    step(1, 0, 0, 1, e);
    step(0, 1, 0, 0, '0);

    // Consecutive stream 0x1..0x3 followed by a bubble.
    for (int i = 1; i <= 3; i++) begin
      e = '0;
      e.inst = IW'(i);
      step(1, 1, 0, 0, e);
    end
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0);

    // Stall with main holding 0x100, offer 0x104, then release.
    e = rand_ent(); e.addr = 40'h100;
    step(1, 0, 0, 0, e);
    e = rand_ent(); e.addr = 40'h104;
    step(1, 0, 0, 0, e);
    step(0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0);

    // Fill, then flush while offering inst 0x5.
    step(1, 0, 0, 0, rand_ent());
    step(1, 0, 0, 0, rand_ent());
    e = rand_ent(); e.inst = 32'h5;
    step(1, 1, 1, 0, e);
    step(0, 1, 0, 0, '0);
    step(0, 1, 0, 0, '0);

    // Ready toggling on a held entry, then full-rate burst.
    step(1, 0, 0, 0, rand_ent());
    step(1, 0, 0, 0, rand_ent());
    step(1, 1, 0, 0, rand_ent());
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, rand_ent());
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0);

    // Random valid/ready stalls with rare flush and reset.
    start = n_acc;
    cyc = 0;
    while ((n_acc - start) < 10000 && cyc < 60000) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) == 0, $urandom_range(0, 999) == 0, rand_ent());
      cyc++;
    end
    chk("random_entries_done", CW'((n_acc - start) >= 10000), CW'(1));

    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, '0);
    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_elastic.md
ID_EX_ELASTIC -- requirements
Module: id_ex_elastic

Interface
REQ-001 Parameter ADDR_W, default 32, width of instruction address field.
REQ-002 Parameter DATA_W, default 32, width of rsvalue/rtvalue/imm fields.
REQ-003 Parameter REG_W, default 5, width of destination register index.
REQ-004 Parameter INST_W, default 32, width of instruction word.
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  synchronous kill of all held entries (branch/exception squash).
REQ-008 input_valid  input  1  upstream (ID) presents a valid entry.
REQ-009 input_ready  output  1  stage can accept an entry this cycle.
REQ-010 input_addr / input_inst / input_write_reg  input  ADDR_W / INST_W / REG_W  entry address, instruction, destination register.
REQ-011 input_rsvalue / input_rtvalue / input_imm  input  DATA_W each  operand and immediate values.
REQ-012 output_valid  output  1  EX-side entry valid.
REQ-013 output_ready  input  1  EX consumes the presented entry this cycle.
REQ-014 output_addr / output_inst / output_write_reg / output_rsvalue / output_rtvalue / output_imm  output  widths as REQ-010/011  registered entry to EX.
REQ-015 occupancy  output  2  number of entries held (0..2).

Function
REQ-016 Accept = input_valid && input_ready; consume = output_valid && output_ready; evaluated at each rising edge.
REQ-017 Block SHALL hold a main register (drives outputs) and, when compiled in, one skid register; entries SHALL leave in acceptance order, no loss, no duplication.
REQ-018 Accept with main empty, or main consumed same cycle and skid empty: entry SHALL load main, output_valid=1 next cycle (latency 1 cycle).
REQ-019 Accept with main full and not consumed: entry SHALL load skid.
REQ-020 Consume with skid full: skid SHALL move to main next cycle; skid becomes empty.
REQ-021 Consume with skid empty and no accept: output_valid SHALL go 0 next cycle.
REQ-022 All output payload fields SHALL be zero whenever output_valid=0 (bubble = all-zero NOP entry).
REQ-023 Payload fields SHALL remain stable while output_valid=1 and output_ready=0.
REQ-024 flush=1 SHALL, next cycle, clear both entries, output_valid=0, payload zero, occupancy=0; an entry accepted in the flush cycle SHALL be discarded; flush has priority over accept and consume.
REQ-025 occupancy SHALL equal main valid + skid valid, registered.
REQ-026 output_valid, occupancy and input_ready SHALL change only at clock edges except where REQ-033 permits.

Reset
REQ-027 reset=1 SHALL, next edge, clear main and skid: output_valid=0, all payload outputs 0, occupancy=0.
REQ-028 input_ready SHALL be 1 in the cycle after reset deasserts.
REQ-029 reset SHALL have priority over flush, accept and consume; reset mid-transfer discards held entries.

Configuration
REQ-030 Macro ID_EX_ELASTIC_SKID_EN selects the skid register.
REQ-031 With ID_EX_ELASTIC_SKID_EN defined: input_ready = skid empty, registered, no combinational path from output_ready to input_ready; occupancy up to 2.
REQ-032 With it defined, back-to-back accept every cycle SHALL sustain with output_ready=1 continuously (full throughput).
REQ-033 Without it: no skid register; input_ready = !output_valid || output_ready (combinational); occupancy never exceeds 1; REQ-019/020 do not apply.

Verification
REQ-034 Reset held 2 cycles with input_valid=1, input_inst=0x2402000A -> output_valid=0, all outputs 0, occupancy=0; after release input_ready=1.
REQ-035 Stream inst 0x1,0x2,0x3 on consecutive cycles, output_ready=1 -> outputs 0x1,0x2,0x3 on cycles 1..3 after acceptance, then bubble (valid=0, inst=0).
REQ-036 (SKID_EN) Main holds addr 0x100, output_ready=0, accept addr 0x104 -> occupancy=2, input_ready=0; output_ready=1 -> 0x100 then 0x104 presented, input_ready=1 again.
REQ-037 Occupancy=2, flush=1 with input_valid=1 (inst 0x5) -> next cycle output_valid=0, occupancy=0, inst 0x5 never appears at output.
REQ-038 (no SKID_EN) output_valid=1, output_ready=0 -> input_ready=0 same cycle; set output_ready=1 -> input_ready=1 same cycle, new entry presented next cycle.
REQ-039 Random valid/ready stalls, 10000 entries with DATA_W=64, ADDR_W=40 -> scoreboard order and payload match, occupancy never exceeds 2 (1 without SKID_EN).
